reg_ctx_engine: RTL and testbench

Context save/restore sequencer for the 8-entry, 8-bit general-purpose register file. On command it reads all eight registers through a register-file read port and writes them to data memory at a base address (save). It also reads eight bytes from memory and writes them back through the register-file write port (restore). It sits between the interrupt/control unit and the memory bus, and is the register file's bulk-access counterpart.

---
 rtl/reg_ctx_engine.sv | 137 +++++++++++++
 tb/tb_reg_ctx_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer: bulk-copies the 8x8 register file
// to data memory (save) or back from memory (restore).
module reg_ctx_engine #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_start,
  input  logic              restore_start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        rf_raddr,
  input  logic [7:0]        rf_rdata,
  output logic              rf_wen,
  output logic [2:0]        rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] cur_addr;

  assign cur_addr = base_q + ADDR_W'(idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      base_q  <= '0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    base_d    = base_q;
    data_d    = data_q;
    busy      = 1'b0;
    done      = 1'b0;
    rf_raddr  = 3'd0;
    rf_wen    = 1'b0;
    rf_waddr  = 3'd0;
    rf_wdata  = 8'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        // save has priority; a simultaneous restore is dropped
        if (save_start) begin
          base_d  = base_addr;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          state_d = S_SAVE;
        end else if (restore_start) begin
          base_d  = base_addr;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          state_d = S_RD;
        end
      end
      S_SAVE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        rf_raddr  = idx_q;
        mem_addr  = cur_addr;
        mem_wdata = rf_rdata;
        if (mem_ack) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + 3'd1;
            last_d = (idx_q == 3'd6);
          end
        end
      end
      S_RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = cur_addr;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_WR;
        end
      end
      S_WR: begin
        busy     = 1'b1;
        rf_wen   = 1'b1;
        rf_waddr = idx_q;
        rf_wdata = data_q;
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          last_d  = (idx_q == 3'd6);
          state_d = S_RD;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Scoreboard bench for reg_ctx_engine: random save/restore traffic
// against array models of the register file and data memory.
module tb_reg_ctx_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       save_start = 1'b0;
  logic       restore_start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic       busy, done, rf_wen, mem_req, mem_we;
  logic [2:0] rf_raddr, rf_waddr;
  logic [7:0] rf_rdata, rf_wdata, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       mem_ack = 1'b0;

  always #5 clk = ~clk;

  reg_ctx_engine #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .save_start(save_start), .restore_start(restore_start),
    .base_addr(base_addr), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // register file model
  logic [7:0] rf [8] = '{8'h10, 8'h11, 8'h12, 8'h13,
                         8'h14, 8'h15, 8'h16, 8'h17};
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk) if (rf_wen) rf[rf_waddr] <= rf_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_exp_t;

  mem_exp_t    mem_q[$];
  logic [10:0] rf_q[$];
  int          done_q[$];
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_rf [8];
  int passed = 0, total = 0;
  int start_cyc = 0, busy_cnt = 0, done_seen = 0, rf_seen = 0;
  int wait_n = 0;
  bit spur_en = 1'b0;

  function automatic logic [7:0] init_byte(int a);
    if (a >= 'h80 && a < 'h88) return 8'(8'hA0 + a - 'h80);
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail(string name, logic [63:0] act);
    total++;
    $display("FAIL %s: got %0h required nothing", name, act);
  endtask

  task automatic responder();
    int wcnt;
    wcnt = 0;
    for (int a = 0; a < 256; a++) mem[a] = init_byte(a);
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = 8'd0;
      if (mem_req) begin
        if (wcnt >= wait_n) begin
          mem_ack = 1'b1;
          wcnt = 0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem[mem_addr];
        end else wcnt++;
      end else begin
        wcnt = 0;
        if (spur_en && (rf_wen || !busy) && $urandom_range(0, 1) == 1) begin
          mem_ack = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end
    end
  endtask

  task automatic monitor();
    logic        hold;
    logic [9:0]  prev;
    mem_exp_t    e;
    logic [10:0] r;
    int          lat;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
        hold = 1'b0;
        continue;
      end
      if (busy) busy_cnt++;
      else check("idle_outs", {done, rf_wen, mem_req, mem_we, rf_raddr,
                 rf_waddr, rf_wdata, mem_addr, mem_wdata}, 0);
      if (hold) check("req_stable", {mem_req, mem_we, mem_addr}, prev);
      hold = mem_req && !mem_ack;
      prev = {mem_req, mem_we, mem_addr};
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) fail("mem_unexpected", {mem_we, mem_addr});
        else begin
          e = mem_q.pop_front();
          check("mem_access", {mem_we, mem_addr, mem_wdata}, e);
        end
      end
      if (rf_wen) begin
        rf_seen++;
        if (rf_q.size() == 0) fail("rf_unexpected", {rf_waddr, rf_wdata});
        else begin
          r = rf_q.pop_front();
          check("rf_write", {rf_waddr, rf_wdata}, r);
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) fail("done_unexpected", cyc);
        else begin
          lat = done_q.pop_front();
          check("done_latency", cyc - start_cyc, lat);
          check("busy_cycles", busy_cnt, lat);
        end
        busy_cnt = 0;
      end
    end
  endtask

  task automatic run_op(bit is_save, logic [7:0] base, int w,
                        bit both, bit mid_restore);
    int d0;
    logic [7:0] a;
    wait_n = w;
    @(posedge clk); #1;
    save_start = is_save;
    restore_start = !is_save || both;
    base_addr = base;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      a = base + 8'(i);
      if (is_save) begin
        mem_q.push_back({1'b1, a, ref_rf[i]});
        ref_mem[a] = ref_rf[i];
      end else begin
        mem_q.push_back({1'b0, a, 8'h00});
        rf_q.push_back({3'(i), ref_mem[a]});
        ref_rf[i] = ref_mem[a];
      end
    end
    done_q.push_back(is_save ? 8 * (w + 1) + 1 : 8 * (w + 2) + 1);
    d0 = done_seen;
    for (int n = 0; n < 400 && done_seen == d0; n++) begin
      @(posedge clk); #1;
      save_start = 1'b0;
      restore_start = mid_restore && n == 2;
      base_addr = 8'($urandom);
    end
    restore_start = 1'b0;
    if (done_seen == d0) fail("done_timeout", cyc);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 8; i++)
      check($sformatf("rf_r%0d", i), rf[i], ref_rf[i]);
  endtask

  initial begin
    logic [7:0] a;
    int r0;
    bit found;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'(8'h10 + i);
    fork
      responder();
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, rf_wen, mem_req, mem_we, rf_raddr,
          rf_waddr, rf_wdata, mem_addr, mem_wdata}, 0);
    reset = 1'b0;

    run_op(1'b1, 8'h40, 0, 1'b0, 1'b0);
    run_op(1'b0, 8'h80, 2, 1'b0, 1'b0);
    check_rf();
    run_op(1'b1, 8'hFE, 0, 1'b0, 1'b0);
    run_op(1'b1, 8'($urandom), 1, 1'b1, 1'b1);

    // abort a restore while reading index 3
    wait_n = 2;
    @(posedge clk); #1;
    restore_start = 1'b1;
    base_addr = 8'h30;
    start_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      a = 8'h30 + 8'(i);
      mem_q.push_back({1'b0, a, 8'h00});
      rf_q.push_back({3'(i), ref_mem[a]});
      ref_rf[i] = ref_mem[a];
    end
    r0 = rf_seen;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk); #1;
      restore_start = 1'b0;
      found = (rf_seen == r0 + 3) && mem_req;
    end
    if (!found) fail("abort_timeout", rf_seen);
    #2 reset = 1'b1;
    #1 check("abort_outs", {mem_req, busy, rf_wen, done}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_rf();
    run_op(1'b1, 8'h00, 0, 1'b0, 1'b0);

    spur_en = 1'b1;
    repeat (20)
      run_op(1'($urandom_range(0, 1)), 8'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_rf();
    for (int i = 0; i < 256; i++)
      check($sformatf("mem_%0h", i), mem[i], ref_mem[i]);
    check("mem_q_empty", mem_q.size(), 0);
    check("rf_q_empty", rf_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
